// File: rtl/alu_operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// alu_defs : definitions shared by the ALU and its operand loader.
//   - Op-code constants for the eight supported ALU operations.
//   - One-hot state encodings of the loader FSM. The encodings double as the
//     state_leds pattern.
//   - is_legal_op(): legality decode for an incoming 6-bit op code.
// -----------------------------------------------------------------------------
package alu_defs;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // One-hot so the state register drives the indicator LEDs directly.
  typedef enum logic [3:0] {
    ST_WAIT_A  = 4'b0001,
    ST_WAIT_B  = 4'b0010,
    ST_WAIT_OP = 4'b0100,
    ST_SHOW    = 4'b1000
  } state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// -----------------------------------------------------------------------------
// alu_operand_loader_if : board-side and ALU-side signals of the loader.
//   sw           switch bank (A, B and op-code source; op code is sw[5:0])
//   btn_load     raw bouncing load button
//   buf_A/buf_B  latched signed operands
//   buf_Op       latched op code
//   result_valid high while a complete operand set is shown
//   op_error     one-cycle pulse when an illegal op code is rejected
//   state_leds   one-hot state indicator
// master: the board / test side that drives sw and btn_load.
// slave : the loader itself.
// -----------------------------------------------------------------------------
interface alu_operand_loader_if #(
  parameter int nbits = 8
);
  logic        [nbits-1:0] sw;
  logic                    btn_load;
  logic signed [nbits-1:0] buf_A;
  logic signed [nbits-1:0] buf_B;
  logic        [5:0]       buf_Op;
  logic                    result_valid;
  logic                    op_error;
  logic        [3:0]       state_leds;

  modport master (
    output sw, btn_load,
    input  buf_A, buf_B, buf_Op, result_valid, op_error, state_leds
  );

  modport slave (
    input  sw, btn_load,
    output buf_A, buf_B, buf_Op, result_valid, op_error, state_leds
  );
endinterface

// File: rtl/alu_operand_loader_btn_debouncer.sv
// -----------------------------------------------------------------------------
// btn_debouncer : conditions a raw push button into a one-cycle press strobe.
//   clk      system clock
//   reset    synchronous active-high reset
//   raw_i    raw asynchronous, bouncing button level
//   press_o  registered one-cycle strobe on each debounced 0->1 transition
// The level must differ from the debounced level for DEBOUNCE_CYCLES
// consecutive cycles before the debounced level follows it.
// -----------------------------------------------------------------------------
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             deb_q, deb_prev_q;
  logic             press_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      // synchronizer
      sync1_q <= raw_i;
      sync2_q <= sync1_q;

      // stability counter: the edge that would bring it to DEBOUNCE_CYCLES
      // commits the new level instead.
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        deb_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // rising-edge strobe; release generates nothing
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader : sequential operand front end for the nbits-wide ALU.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    alu_operand_loader_if slave port:
//            in : sw, btn_load
//            out: buf_A, buf_B, buf_Op, result_valid, op_error, state_leds
// Each debounced press captures the switch bank into the next slot
// (A, then B, then op code). Illegal op codes are rejected with an op_error
// pulse. A press while showing the result returns to WAIT_A without
// disturbing the buffers, so the ALU output stays stable until the next A.
// -----------------------------------------------------------------------------
module alu_operand_loader
  import alu_defs::*;
#(
  parameter int nbits           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                clk,
  input logic                reset,
  alu_operand_loader_if.slave bus
);

  logic press;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (bus.btn_load),
    .press_o(press)
  );

  state_e                  state_q;
  logic signed [nbits-1:0] buf_a_q;
  logic signed [nbits-1:0] buf_b_q;
  logic        [5:0]       buf_op_q;
  logic                    result_valid_q;
  logic                    op_error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_WAIT_A;
      buf_a_q        <= '0;
      buf_b_q        <= '0;
      buf_op_q       <= 6'b000000;
      result_valid_q <= 1'b0;
      op_error_q     <= 1'b0;
    end else begin
      op_error_q <= 1'b0;
      if (press) begin
        case (state_q)
          ST_WAIT_A: begin
            buf_a_q <= bus.sw;
            state_q <= ST_WAIT_B;
          end
          ST_WAIT_B: begin
            buf_b_q <= bus.sw;
            state_q <= ST_WAIT_OP;
          end
          ST_WAIT_OP: begin
            if (is_legal_op(bus.sw[5:0])) begin
              buf_op_q       <= bus.sw[5:0];
              state_q        <= ST_SHOW;
              result_valid_q <= 1'b1;
            end else begin
              op_error_q <= 1'b1;
            end
          end
          ST_SHOW: begin
            state_q        <= ST_WAIT_A;
            result_valid_q <= 1'b0;
          end
          default: begin
            state_q        <= ST_WAIT_A;
            result_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.buf_A        = buf_a_q;
  assign bus.buf_B        = buf_b_q;
  assign bus.buf_Op       = buf_op_q;
  assign bus.result_valid = result_valid_q;
  assign bus.op_error     = op_error_q;
  assign bus.state_leds   = state_q;

endmodule
